// File: rtl/thermostat_pkg.sv
// Shared types and defaults for the thermostat temperature-sense block.
package thermostat_pkg;

    localparam int TEMP_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_COLD   = 2'd1,
        ST_HOT    = 2'd2
    } therm_state_t;

endpackage

// File: rtl/thermostat_debounce_ctr.sv
// Debounce counter: counts consecutive qualifying samples up to DEBOUNCE.
// done pulses (combinationally) on the increment that reaches DEBOUNCE, and
// the count then returns to zero. clr together with inc restarts the count at 1.
module thermostat_debounce_ctr #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // cnt never exceeds DEBOUNCE-1, so the increment cannot wrap
    assign cnt_next = (clr ? '0 : cnt) + CNT_W'(1);
    assign done     = inc & (cnt_next == TERM);

    // Count register: terminal count and clear both return to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_next;
        end else if (clr) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/thermostat_temp_sense.sv
// Temperature sample conditioner: compares accepted samples against a
// programmable setpoint with hysteresis and debounce, and drives registered
// too_cold / too_hot request flags.
//
// state     | meaning
// ----------|-----------------------------------------------
// ST_NORMAL | within band; watching for cold or hot runs
// ST_COLD   | too_cold asserted; waiting for temp >= setpoint
// ST_HOT    | too_hot asserted; waiting for temp <= setpoint
module thermostat_temp_sense
    import thermostat_pkg::*;
#(
    parameter int TEMP_W       = TEMP_W_DEF,
    parameter int HYST         = 2,
    parameter int DEBOUNCE     = 3,
    parameter int SETPOINT_RST = 70
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              setpoint_wen,
    input  logic [TEMP_W-1:0] setpoint_wdata,
    input  logic              samp_val,
    output logic              samp_rdy,
    input  logic [TEMP_W-1:0] samp_temp,
    output logic              too_cold,
    output logic              too_hot,
    output logic [TEMP_W-1:0] setpoint
);

    localparam logic [TEMP_W:0] HYST_X   = (TEMP_W+1)'(HYST);
    localparam logic [TEMP_W:0] TEMP_MAX = {1'b0, {TEMP_W{1'b1}}};

    therm_state_t    state;
    logic            last_hot;
    logic [TEMP_W:0] sp_x, temp_x, hi_sum, lo, hi;
    logic            cold_qual, hot_qual;
    logic            qual, dir_switch;
    logic            accept, inc, clr, done;

    // A setpoint write takes the cycle; the sample stays pending upstream
    assign samp_rdy = ~reset & ~setpoint_wen;
    assign accept   = samp_val & samp_rdy;

    // Saturating thresholds, one bit wider than the samples
    assign sp_x   = {1'b0, setpoint};
    assign temp_x = {1'b0, samp_temp};
    assign hi_sum = sp_x + HYST_X;
    assign lo     = (sp_x < HYST_X) ? '0 : (sp_x - HYST_X);
    assign hi     = (hi_sum > TEMP_MAX) ? TEMP_MAX : hi_sum;

    assign cold_qual = temp_x < lo;
    assign hot_qual  = temp_x > hi;

    // Per-state qualifying condition; in NORMAL a change of direction restarts the run
    always_comb begin
        qual       = 1'b0;
        dir_switch = 1'b0;
        case (state)
            ST_NORMAL: begin
                qual       = cold_qual | hot_qual;
                dir_switch = (hot_qual & ~last_hot) | (cold_qual & last_hot);
            end
            ST_COLD: qual = (samp_temp >= setpoint);
            ST_HOT:  qual = (samp_temp <= setpoint);
            default: qual = 1'b0;
        endcase
    end

    assign inc = accept & qual;
    assign clr = setpoint_wen | (accept & ~qual) | (inc & dir_switch);

    thermostat_debounce_ctr #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .clr   (clr),
        .done  (done)
    );

    // Setpoint register
    always_ff @(posedge clk) begin
        if (reset) begin
            setpoint <= TEMP_W'(SETPOINT_RST);
        end else if (setpoint_wen) begin
            setpoint <= setpoint_wdata;
        end
    end

    // Condition FSM with registered request flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_NORMAL;
            last_hot <= 1'b0;
            too_cold <= 1'b0;
            too_hot  <= 1'b0;
        end else if (inc) begin
            if (state == ST_NORMAL) begin
                last_hot <= hot_qual;
            end
            if (done) begin
                case (state)
                    ST_NORMAL: begin
                        if (hot_qual) begin
                            state   <= ST_HOT;
                            too_hot <= 1'b1;
                        end else begin
                            state    <= ST_COLD;
                            too_cold <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_NORMAL;
                        too_cold <= 1'b0;
                        too_hot  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_thermostat_temp_sense.sv
// Scoreboard bench for thermostat_temp_sense: the driver runs a behavioural
// model and queues expected outputs; independent monitors compare them.
module tb_thermostat_temp_sense;

    localparam int TEMP_W = 8;
    localparam int HYST   = 2;
    localparam int DEB    = 3;
    localparam int SP_RST = 70;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              setpoint_wen = 1'b0;
    logic [TEMP_W-1:0] setpoint_wdata = '0;
    logic              samp_val = 1'b0;
    logic              samp_rdy;
    logic [TEMP_W-1:0] samp_temp = '0;
    logic              too_cold, too_hot;
    logic [TEMP_W-1:0] setpoint;

    thermostat_temp_sense #(
        .TEMP_W(TEMP_W), .HYST(HYST), .DEBOUNCE(DEB), .SETPOINT_RST(SP_RST)
    ) dut (
        .clk(clk), .reset(reset),
        .setpoint_wen(setpoint_wen), .setpoint_wdata(setpoint_wdata),
        .samp_val(samp_val), .samp_rdy(samp_rdy), .samp_temp(samp_temp),
        .too_cold(too_cold), .too_hot(too_hot), .setpoint(setpoint)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cold;
        logic hot;
        int   sp;
    } out_t;

    logic rdy_q[$];
    out_t out_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done_drv = 1'b0;

    // Behavioural model: mode 0 normal, 1 cold, 2 hot; run = current qualifying run length
    int m_mode = 0, m_run = 0, m_dir = 0, m_sp = SP_RST;

    task automatic step(input bit rst, input bit wen, input int wdata, input bit val, input int temp);
        out_t e;
        int lo, hi, d;
        @(negedge clk);
        reset          = rst;
        setpoint_wen   = wen;
        setpoint_wdata = TEMP_W'(wdata);
        samp_val       = val;
        samp_temp      = TEMP_W'(temp);
        rdy_q.push_back(!rst && !wen);
        if (rst) begin
            m_mode = 0; m_run = 0; m_dir = 0; m_sp = SP_RST;
        end else if (wen) begin
            m_sp = wdata; m_run = 0;
        end else if (val) begin
            lo = (m_sp - HYST < 0) ? 0 : m_sp - HYST;
            hi = (m_sp + HYST > 255) ? 255 : m_sp + HYST;
            if (m_mode == 0) begin
                d = (temp < lo) ? -1 : (temp > hi) ? 1 : 0;
                if (d == 0) m_run = 0;
                else if (d == m_dir && m_run > 0) m_run++;
                else m_run = 1;
                if (d != 0) m_dir = d;
                if (m_run == DEB) begin
                    m_mode = (d < 0) ? 1 : 2;
                    m_run = 0;
                end
            end else begin
                if ((m_mode == 1 && temp >= m_sp) || (m_mode == 2 && temp <= m_sp)) m_run++;
                else m_run = 0;
                if (m_run == DEB) begin
                    m_mode = 0;
                    m_run = 0;
                end
            end
        end
        e.cold = (m_mode == 1);
        e.hot  = (m_mode == 2);
        e.sp   = m_sp;
        out_q.push_back(e);
    endtask

    task automatic samp(input int temp);
        step(0, 0, 0, 1, temp);
    endtask

    // Ready monitor: checks samp_rdy mid-cycle against the driver's expectation
    initial begin
        logic er;
        forever begin
            @(negedge clk);
            #2;
            if (rdy_q.size() > 0) begin
                er = rdy_q.pop_front();
                tests++;
                if (samp_rdy !== er) begin
                    fails++;
                    $display("FAIL samp_rdy @%0t: got %b expected %b", $time, samp_rdy, er);
                end
            end
        end
    end

    // Output monitor: checks flags and setpoint just after each rising edge
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                tests++;
                if (too_cold !== e.cold || too_hot !== e.hot || setpoint !== TEMP_W'(e.sp)) begin
                    fails++;
                    $display("FAIL flags @%0t: got cold=%b hot=%b sp=%0d expected cold=%b hot=%b sp=%0d",
                             $time, too_cold, too_hot, setpoint, e.cold, e.hot, e.sp);
                end
                tests++;
                if (too_cold === 1'b1 && too_hot === 1'b1) begin
                    fails++;
                    $display("FAIL exclusive @%0t: got cold=1 hot=1 expected not both", $time);
                end
            end
        end
    end

    initial begin
        int t, r;
        // reset and threshold edge: 68 never qualifies, 67 x3 enters COLD
        step(1, 0, 0, 1, 67);
        step(1, 1, 99, 1, 67);
        repeat (4) samp(68);
        repeat (3) samp(67);
        step(0, 0, 0, 0, 0);
        // exit COLD after 69,70,70,70; then 73 x3 to HOT; 72 does not qualify
        samp(69); samp(70); samp(70); samp(70);
        repeat (3) samp(73);
        samp(72); samp(72);
        repeat (3) samp(70);
        // counter cleared by a non-qualifying sample
        step(1, 0, 0, 0, 0);
        samp(67); samp(67); samp(69); samp(67); samp(67); samp(67);
        // setpoint write stalls a sample and clears pending count
        step(1, 0, 0, 0, 0);
        samp(60); samp(60);
        step(0, 1, 80, 1, 77);
        repeat (3) samp(77);
        // lo clamps to 0, hi clamps to 255
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        repeat (5) samp(0);
        step(0, 1, 254, 0, 0);
        repeat (5) samp(255);
        // reset mid-debounce discards the partial count
        step(1, 0, 0, 0, 0);
        samp(67); samp(67);
        step(1, 0, 0, 1, 67);
        samp(67);
        step(0, 0, 0, 0, 0);
        // hot/cold direction switch restarts the run
        samp(60); samp(60); samp(80); samp(80); samp(60);
        // randomized traffic around the setpoint
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1, 0, 0, $urandom_range(0, 1), 0);
            end else if (r < 4) begin
                t = $urandom_range(0, 9);
                step(0, 1, (t == 0) ? 0 : (t == 1) ? 255 : (t == 2) ? 1 : (t == 3) ? 254
                          : $urandom_range(20, 230), $urandom_range(0, 1), m_sp);
            end else begin
                t = m_sp + $urandom_range(0, 12) - 6;
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                step(0, 0, 0, (r < 80), t);
            end
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #3;
        tests++;
        if (rdy_q.size() != 0 || out_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", rdy_q.size(), out_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
